// File: rtl/counter_2.sv
// Mod-10 up counter driving one seven-segment digit.
// Segment order q[6:0] = a,b,c,d,e,f,g; SEG_ACTIVE_LOW inverts all bits.
module counter_2 #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] q
);

  logic [3:0] count;
  logic [6:0] seg;

  // digit register: async clear, 0..9 then wrap; illegal codes fall back to 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (count >= 4'd9) begin
      count <= 4'd0;
    end else begin
      count <= count + 4'd1;
    end
  end

  // active-high segment decode; codes 10..15 blank the display
  always_comb begin
    seg = 7'b0000000;
    case (count)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

  assign q = SEG_ACTIVE_LOW ? ~seg : seg;

endmodule

// File: tb/tb_counter_2.sv
// Bench for counter_2: directed stimulus feeding a queue-based scoreboard.
// Both segment polarities run side by side from one clock and reset.
module tb_counter_2;

  logic       clk;
  logic       reset;
  logic [6:0] q0;
  logic [6:0] q1;

  typedef struct {
    string      name;
    logic [6:0] e0;
    logic [6:0] e1;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;
  int   cnt;
  logic [6:0] pat [10];

  counter_2 #(.SEG_ACTIVE_LOW(1'b0)) u_hi (
    .clk  (clk),
    .reset(reset),
    .q    (q0)
  );

  counter_2 #(.SEG_ACTIVE_LOW(1'b1)) u_lo (
    .clk  (clk),
    .reset(reset),
    .q    (q1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic expect_digit(input string name, input int d);
    exp_t e;
    e.name = name;
    e.e0   = pat[d];
    e.e1   = ~pat[d];
    sb.push_back(e);
  endtask

  // one rising edge, then let the bench model follow
  task automatic step(input string name);
    @(posedge clk);
    #1;
    if (!reset) cnt = 0;
    else cnt = (cnt == 9) ? 0 : cnt + 1;
    expect_digit(name, cnt);
  endtask

  // monitor: compares whenever an expectation is pending
  initial begin
    exp_t e;
    forever begin
      wait (sb.size() > 0);
      e = sb.pop_front();
      total++;
      if (q0 !== e.e0) begin
        bad++;
        $display("FAIL %s hi: got %b want %b", e.name, q0, e.e0);
      end
      total++;
      if (q1 !== e.e1) begin
        bad++;
        $display("FAIL %s lo: got %b want %b", e.name, q1, e.e1);
      end
    end
  end

  initial begin
    int guard;
    total = 0;
    bad   = 0;
    cnt   = 0;
    pat[0] = 7'b1111110;
    pat[1] = 7'b0110000;
    pat[2] = 7'b1101101;
    pat[3] = 7'b1111001;
    pat[4] = 7'b0110011;
    pat[5] = 7'b1011011;
    pat[6] = 7'b1011111;
    pat[7] = 7'b1110000;
    pat[8] = 7'b1111111;
    pat[9] = 7'b1111011;

    reset = 1'b0;
    #5;
    expect_digit("pwrup", 0);
    step("pwrup_e1");
    step("pwrup_e2");

    @(negedge clk);
    reset = 1'b1;
    step("rel_d1");
    step("rel_d2");
    step("rel_d3");
    step("rel_d4");
    for (int i = 0; i < 6; i++) step("to_zero");
    if (cnt != 0) begin
      total++;
      bad++;
      $display("FAIL model_zero: got %0d want 0", cnt);
    end
    for (int i = 0; i < 10; i++) step("wrap_walk");

    for (int i = 0; i < 6; i++) step("to_six");
    @(negedge clk);
    reset = 1'b0;
    #1;
    cnt = 0;
    expect_digit("mid_rst", 0);
    step("hold_e1");
    step("hold_e2");
    @(negedge clk);
    reset = 1'b1;
    step("restart");

    @(negedge clk);
    reset = 1'b0;
    #1;
    cnt = 0;
    expect_digit("long_rst", 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) step("long_run");
    expect_digit("long_end", 0);

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
